// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 Viterbi frame sequencer.
//   state_t       controller states
//   NUM_STATES    trellis states (2**(K-1))
//   K             constraint length
//   prev_state()  trellis predecessor of state s given its decision bit
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NUM_STATES = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACS,
        STORE,
        TB_RD,
        TB_STEP
    } state_t;

    // Shift the decision bit in as the new LSB; the old LSB becomes the MSB.
    function automatic logic [K-2:0] prev_state(input logic [K-2:0] s, input logic dec);
        return {s[0], dec};
    endfunction

endpackage

// File: rtl/viterbi_ctrl_if.sv
// Bus bundle between the Viterbi sequencer and its surroundings.
//   symbol in : sym_valid, sym_ready, sym, sym_q
//   datapath  : acs_en, pm_msb, pm_sub, best
//   survivor  : sm_we, sm_re, sm_addr, sm_rdata
//   bit out   : out_valid, out_ready, out_bit, out_last
// Modports: master = sequencer, slave = environment.
interface viterbi_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    import viterbi_pkg::*;

    logic                  sym_valid;
    logic                  sym_ready;
    logic [1:0]            sym;
    logic [1:0]            sym_q;
    logic                  acs_en;
    logic [NUM_STATES-1:0] pm_msb;
    logic                  pm_sub;
    logic [K-2:0]          best;
    logic                  sm_we;
    logic                  sm_re;
    logic [ADDR_W-1:0]     sm_addr;
    logic [NUM_STATES-1:0] sm_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_bit;
    logic                  out_last;

    modport master (
        input  sym_valid, sym, pm_msb, best, sm_rdata, out_ready,
        output sym_ready, sym_q, acs_en, pm_sub, sm_we, sm_re, sm_addr,
               out_valid, out_bit, out_last
    );

    modport slave (
        output sym_valid, sym, pm_msb, best, sm_rdata, out_ready,
        input  sym_ready, sym_q, acs_en, pm_sub, sm_we, sm_re, sm_addr,
               out_valid, out_bit, out_last
    );

endinterface

// File: rtl/viterbi_tb_step.sv
// One traceback step (combinational).
//   tb_state      current traceback state
//   sm_rdata      survivor decision bits for all states at this time step
//   tb_state_nxt  predecessor state
//   out_bit       decoded bit carried by the current state (its MSB)
module viterbi_tb_step
    import viterbi_pkg::*;
(
    input  logic [K-2:0]          tb_state,
    input  logic [NUM_STATES-1:0] sm_rdata,
    output logic [K-2:0]          tb_state_nxt,
    output logic                  out_bit
);

    always_comb begin
        out_bit      = tb_state[K-2];
        tb_state_nxt = prev_state(tb_state, sm_rdata[tb_state]);
    end

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the K=3, rate-1/2 Viterbi decoder.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         viterbi_ctrl_if.master: symbol handshake, ACS/normalization
//               strobes, survivor memory port, decoded-bit stream
// Accepts one symbol per 3 cycles, stores decisions, and after FRAME_LEN
// symbols traces back from the best state, emitting bits in reverse order.
// Optional: VITERBI_NORM_EN enables the pm_sub normalization strobe.
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PM_W   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    viterbi_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [K-2:0]      tb_state_q, tb_state_d;
    logic [1:0]        sym_lat_q, sym_lat_d;

    logic              sym_ready, acs_en, pm_sub, sm_we, sm_re;
    logic              out_valid, out_bit, out_last;
    logic [ADDR_W-1:0] sm_addr;
    logic [K-2:0]      tb_nxt;
    logic              tb_bit;

    // Metric width only matters to the datapath; pm_msb is dead without normalization.
    logic unused_cfg;
    assign unused_cfg = ^{bus.pm_msb, PM_W[0]};

    viterbi_tb_step u_tb_step (
        .tb_state     (tb_state_q),
        .sm_rdata     (bus.sm_rdata),
        .tb_state_nxt (tb_nxt),
        .out_bit      (tb_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tb_state_q <= '0;
            sym_lat_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tb_state_q <= tb_state_d;
            sym_lat_q  <= sym_lat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tb_state_d = tb_state_q;
        sym_lat_d  = sym_lat_q;
        sym_ready  = 1'b0;
        acs_en     = 1'b0;
        pm_sub     = 1'b0;
        sm_we      = 1'b0;
        sm_re      = 1'b0;
        sm_addr    = '0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        out_last   = 1'b0;

        case (state_q)
            IDLE: begin
                sym_ready = 1'b1;
                if (bus.sym_valid) begin
                    sym_lat_d = bus.sym;
                    state_d   = ACS;
                end
            end
            ACS: begin
                acs_en  = 1'b1;
                state_d = STORE;
            end
            STORE: begin
                sm_we   = 1'b1;
                sm_addr = wr_ptr_q;
`ifdef VITERBI_NORM_EN
                pm_sub  = (bus.pm_msb == 4'b1111);
`else
                pm_sub  = 1'b0;
`endif
                if (wr_ptr_q == LAST_ADDR) begin
                    tb_state_d = bus.best;
                    rd_ptr_d   = LAST_ADDR;
                    state_d    = TB_RD;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            TB_RD: begin
                sm_re   = 1'b1;
                sm_addr = rd_ptr_q;
                state_d = TB_STEP;
            end
            TB_STEP: begin
                // sm_rdata is held by the memory while sm_re is low, so a stall needs no re-read.
                out_valid = 1'b1;
                out_bit   = tb_bit;
                out_last  = (rd_ptr_q == '0);
                if (bus.out_ready) begin
                    tb_state_d = tb_nxt;
                    if (rd_ptr_q == '0) begin
                        wr_ptr_d = '0;
                        state_d  = IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q - 1'b1;
                        state_d  = TB_RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is forced low while reset is held, even before the reset edge.
    assign bus.sym_ready = sym_ready & rst_n;
    assign bus.sym_q     = rst_n ? sym_lat_q : '0;
    assign bus.acs_en    = acs_en & rst_n;
    assign bus.pm_sub    = pm_sub & rst_n;
    assign bus.sm_we     = sm_we & rst_n;
    assign bus.sm_re     = sm_re & rst_n;
    assign bus.sm_addr   = rst_n ? sm_addr : '0;
    assign bus.out_valid = out_valid & rst_n;
    assign bus.out_bit   = out_bit & rst_n;
    assign bus.out_last  = out_last & rst_n;

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Frame sequencer for the K=3, rate-1/2 Viterbi decoder. Accepts received code-symbol pairs over a valid/ready handshake and strobes the ACS/path-metric datapath once per symbol. Writes each step's decision bits into the survivor memory and keeps the four path metrics in range by normalization. After each full frame it runs traceback from the best state reported by the minimum-metric selector and streams decoded bits downstream.

## Interface
Parameters:
- ADDR_W, 4, survivor address width; frame length FRAME_LEN = 2**ADDR_W symbols (ADDR_W 2..8)
- PM_W, 4, path-metric width; normalization subtracts 2**(PM_W-1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- sym_valid  in  1  received pair available
- sym_ready  out  1  controller can accept a pair
- sym  in  2  received code pair
- sym_q  out  2  latched pair, drives the branch-metric unit
- acs_en  out  1  one-cycle ACS update strobe
- pm_msb  in  4  MSB of pm0..pm3
- pm_sub  out  1  one-cycle normalization strobe
- best  in  2  {d1,d0} from the selector, index of the minimum path metric
- sm_we  out  1  survivor memory write enable
- sm_re  out  1  survivor memory read enable
- sm_addr  out  ADDR_W  survivor memory address
- sm_rdata  in  4  decision bit per state, 1-cycle synchronous read
- out_valid  out  1  decoded bit valid
- out_ready  in  1  downstream accepts
- out_bit  out  1  decoded bit, emitted in reverse time order
- out_last  out  1  marks the final bit of a frame

## Operation
- States: IDLE, ACS, STORE, TB_RD, TB_STEP.
- IDLE:
  - sym_ready = rst_n.
  - On sym_valid & sym_ready: sym_q <= sym, go to ACS.
- ACS: acs_en = 1 for one cycle, then go to STORE.
- STORE:
  - sm_we = 1, sm_addr = wr_ptr.
  - If wr_ptr == FRAME_LEN-1: tb_state <= best, rd_ptr <= FRAME_LEN-1, go to TB_RD.
  - Otherwise: wr_ptr++, go to IDLE.
- TB_RD: sm_re = 1, sm_addr = rd_ptr, go to TB_STEP.
- TB_STEP:
  - out_valid = 1, out_bit = tb_state[1], out_last = (rd_ptr == 0). The output stays in TB_STEP until out_ready.
  - On out_valid & out_ready: tb_state <= {tb_state[0], sm_rdata[tb_state]}.
  - If rd_ptr == 0: wr_ptr <= 0, go to IDLE. Otherwise rd_ptr--, go to TB_RD.
- The survivor memory holds sm_rdata stable while sm_re is low. The controller does not re-read during a stall.
- sym is ignored whenever sym_ready is low; no symbol is accepted during traceback.
- The argmin of the metrics is unaffected by pm_sub, so best needs no correction.
- Pointers are unsigned ADDR_W bits. wr_ptr never wraps; it is cleared explicitly at the end of traceback.

## Timing
- After reset (rst_n low at a clk edge): state IDLE, wr_ptr = rd_ptr = 0, tb_state = 0, sym_q = 0. All outputs are 0, including sym_ready, while rst_n is low.
- Symbol throughput is 3 cycles: accept at edge n, acs_en during cycle n+1, sm_we during cycle n+2, sym_ready high again in cycle n+3.
- Traceback takes at least 2*FRAME_LEN cycles per frame; each out_ready-low cycle adds one.
- The first out_valid comes 2 cycles after the final STORE.
- Reset mid-frame or mid-traceback aborts immediately. The partial frame is discarded, and no out_last is issued for it.
- pm_sub is evaluated only in STORE (metrics are valid after ACS). It is never asserted in two consecutive cycles.

## Configuration
- VITERBI_NORM_EN defined: in STORE, pm_sub = (pm_msb == 4'b1111).
- VITERBI_NORM_EN undefined: pm_sub is tied to 0 and pm_msb is unused. Frames must be short enough that metrics cannot saturate.

## Structure
- viterbi_pkg holds:
  - the state enum;
  - NUM_STATES = 4;
  - the K = 3 constant;
  - the predecessor function prev_state(s, dec) = {s[0], dec}.
- One sub-module, viterbi_tb_step: combinational. It takes tb_state and sm_rdata, and outputs the next tb_state and out_bit. It is instantiated once in the controller.

## Test plan
All scenarios use ADDR_W = 2 (FRAME_LEN = 4).
- Reset, then 4 back-to-back symbols:
  - acs_en pulses at cycles 1, 4, 7, 10;
  - sm_we occurs at addresses 0, 1, 2, 3;
  - sym_ready is low during traceback.
- best = 2'b10 at the last STORE, sm_rdata = 4'b0000 for every read:
  - reads occur at addresses 3, 2, 1, 0;
  - out_bit sequence is 1, 0, 0, 0;
  - out_last accompanies the 4th bit only.
- out_ready held low 3 cycles on the first TB_STEP: out_valid and out_bit stay stable, and sm_re is not re-asserted.
- pm_msb = 4'b1111 during STORE with VITERBI_NORM_EN: pm_sub pulses for exactly 1 cycle. With pm_msb = 4'b0111 there is no pulse. Without the macro, pm_sub stays 0.
- rst_n low for 1 cycle after 2 symbols: all outputs are 0. The next frame writes from address 0, and no out_valid appears for the aborted frame.
- sym_valid held high through ACS, STORE and traceback: exactly one symbol is accepted per IDLE visit.
